grant_xfer_ctrl: RTL and testbench

GRANT_XFER_CTRL -- requirements
Module: grant_xfer_ctrl

---
 rtl/grant_xfer_ctrl.sv | 119 +++++++++++
 tb/tb_grant_xfer_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/grant_xfer_ctrl.sv
// Transfer controller behind a 4-requester arbiter: latches the granted word,
// presents it to the sink with a bounded wait, then acknowledges the requester.
module grant_xfer_ctrl #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      gnt,
  input  logic [4*DW-1:0] din,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_id,
  output logic [3:0]      ack,
  output logic            busy,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic [DW-1:0] data_reg, data_next;
  logic [1:0]    id_reg, id_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic          err_reg, err_next;

  logic [DW-1:0] din_slice [4];
  logic          gnt_onehot;
  logic          gnt_multi;
  logic [1:0]    gnt_idx;

  for (genvar gi = 0; gi < 4; gi++) begin : g_slice
    assign din_slice[gi] = din[gi*DW +: DW];
  end

  // A single set bit leaves zero after clearing the lowest set bit.
  assign gnt_onehot = (gnt != 4'd0) && ((gnt & (gnt - 4'd1)) == 4'd0);
  assign gnt_multi  = (gnt != 4'd0) && !gnt_onehot;

  always_comb begin
    gnt_idx = 2'd0;
    case (gnt)
      4'b0010: gnt_idx = 2'd1;
      4'b0100: gnt_idx = 2'd2;
      4'b1000: gnt_idx = 2'd3;
      default: gnt_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      id_reg    <= 2'd0;
      cnt_reg   <= 8'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      id_reg    <= id_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    id_next    = id_reg;
    cnt_next   = cnt_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (gnt_onehot) begin
          state_next = SEND;
          id_next    = gnt_idx;
          data_next  = din_slice[gnt_idx];
          cnt_next   = 8'd0;
        end else if (gnt_multi) begin
          err_next = 1'b1;
        end
      end
      SEND: begin
        // A ready on the final wait cycle still wins over the timeout.
        if (out_ready) begin
          state_next = ACK;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_reg == SEND);
    busy      = (state_reg != IDLE);
    ack       = 4'd0;
    for (int i = 0; i < 4; i++) begin
      ack[i] = (state_reg == ACK) && (id_reg == 2'(i));
    end
  end

  assign out_data = data_reg;
  assign out_id   = id_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_grant_xfer_ctrl.sv
// Bench for grant_xfer_ctrl: directed scenarios then random traffic, every
// cycle compared against a transaction-phase model of the controller.
module tb_grant_xfer_ctrl;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      gnt;
  logic [4*DW-1:0] din;
  logic            out_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_id;
  logic [3:0]      ack;
  logic            busy;
  logic            err;

  int compared = 0;
  int mismatched = 0;

  // Model: which phase the current transfer is in, and what it carries.
  bit          m_sending, m_acking, m_err;
  int          m_waited;
  int          m_id;
  logic [DW-1:0] m_data;

  int valid_cnt, ack_cnt;

  grant_xfer_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .gnt(gnt), .din(din), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .ack(ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_edge();
    bit nerr;
    nerr = 1'b0;
    if (rst) begin
      m_sending = 0; m_acking = 0; m_waited = 0; m_id = 0; m_data = '0;
    end else if (m_sending) begin
      if (out_ready) begin
        m_sending = 0; m_acking = 1;
      end else if (m_waited == TIMEOUT - 1) begin
        m_sending = 0; nerr = 1'b1;
      end else begin
        m_waited++;
      end
    end else if (m_acking) begin
      m_acking = 0;
    end else if ($countones(gnt) == 1) begin
      for (int i = 0; i < 4; i++) if (gnt[i]) m_id = i;
      m_data    = din[m_id*DW +: DW];
      m_sending = 1;
      m_waited  = 0;
    end else if ($countones(gnt) > 1) begin
      nerr = 1'b1;
    end
    m_err = nerr;
  endtask

  // One clock: inputs already set, update model at the edge, compare after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_sending));
    chk("busy",      32'(busy),      32'(m_sending | m_acking));
    chk("ack",       32'(ack),       m_acking ? (32'd1 << m_id) : 32'd0);
    chk("err",       32'(err),       32'(m_err));
    chk("out_id",    32'(out_id),    32'(m_id));
    chk("out_data",  32'(out_data),  32'(m_data));
    if (out_valid) valid_cnt++;
    if (ack != 4'd0) ack_cnt++;
    $display("t=%0t rst=%b gnt=%b rdy=%b | v=%b id=%0d d=%h ack=%b busy=%b err=%b",
             $time, rst, gnt, out_ready, out_valid, out_id, out_data, ack, busy, err);
  endtask

  initial begin
    rst = 1'b1; gnt = 4'd0; din = '0; out_ready = 1'b0;
    m_sending = 0; m_acking = 0; m_err = 0; m_waited = 0; m_id = 0; m_data = '0;
    @(negedge clk);

    // Reset
    step(); step();
    rst = 1'b0;

    // Basic transfer
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    gnt = 4'b0100; out_ready = 1'b1;
    step();
    chk("basic_data", 32'(out_data), 32'h33);
    gnt = 4'b0000;
    step(); chk("basic_ack", 32'(ack), 32'b0100);
    step(); step();

    // Backpressure: 5 stalled SEND cycles then accept
    gnt = 4'b0001; out_ready = 1'b0; valid_cnt = 0;
    step();
    gnt = 4'b0000;
    repeat (5) step();
    out_ready = 1'b1;
    step(); step(); step();
    chk("bp_valid_cycles", 32'(valid_cnt), 32'd6);

    // Timeout
    gnt = 4'b1000; out_ready = 1'b0; valid_cnt = 0;
    step();
    gnt = 4'b0000;
    repeat (TIMEOUT + 3) step();
    chk("to_valid_cycles", 32'(valid_cnt), 32'(TIMEOUT));

    // Ready on the final wait cycle beats the timeout
    gnt = 4'b0010; valid_cnt = 0;
    step();
    gnt = 4'b0000;
    repeat (TIMEOUT - 1) step();
    out_ready = 1'b1;
    step(); chk("edge_ack", 32'(ack), 32'b0010);
    step();

    // Illegal grant followed by a legal one
    gnt = 4'b1010;
    step();
    gnt = 4'b0010;
    step(); chk("illegal_then_id", 32'(out_id), 32'd1);
    gnt = 4'b0000;
    step(); step();

    // Reset on the third SEND cycle
    gnt = 4'b0010; out_ready = 1'b0;
    step();
    gnt = 4'b0000;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; gnt = 4'b0001; out_ready = 1'b1;
    step(); chk("post_rst_accept", 32'(out_valid), 32'd1);
    gnt = 4'b0000;
    step(); step();

    // Back-to-back with grant held
    gnt = 4'b0001; out_ready = 1'b1; ack_cnt = 0;
    repeat (12) step();
    chk("b2b_ack_count", 32'(ack_cnt), 32'd4);
    gnt = 4'b0000;
    step(); step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      din = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       gnt = 4'd0;
        1:       gnt = 4'($urandom);
        default: gnt = 4'd1 << $urandom_range(0, 3);
      endcase
      out_ready = ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 1'b0; gnt = 4'd0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
